// File: rtl/drbg_nonce_ctrl.sv
// Sequencer between the HMAC-DRBG nonce generator and the ECC datapath: picks init/next,
// handshakes the command, captures the nonce and streams it out MSW first.
module drbg_nonce_ctrl #(
    parameter int unsigned REG_SIZE        = 384,
    parameter int unsigned WORD_SIZE       = 32,
    parameter int unsigned RESEED_INTERVAL = 16,
    parameter int unsigned TIMEOUT         = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 req_mode,
    input  logic                 reseed_force,
    output logic                 busy,
    output logic                 err,
    output logic                 drbg_mode,
    output logic                 drbg_init,
    output logic                 drbg_next,
    input  logic                 drbg_ready,
    input  logic                 drbg_valid,
    input  logic [REG_SIZE-1:0]  drbg_nonce,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_last
);

    localparam int unsigned NUM_WORDS = REG_SIZE / WORD_SIZE;
    localparam int unsigned GEN_W     = $clog2(RESEED_INTERVAL + 1);
    localparam int unsigned WDOG_W    = $clog2(TIMEOUT + 1);
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [GEN_W-1:0]  GEN_MAX   = GEN_W'(RESEED_INTERVAL);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_TRIP = WDOG_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUT,
        S_ERR
    } state_t;

    state_t              state, state_n;
    logic                mode_reg, mode_n;
    logic                use_init, use_init_n;
    logic                inst_valid, inst_valid_n;
    logic                inst_mode, inst_mode_n;
    logic                reseed_pend, reseed_pend_n;
    logic [GEN_W-1:0]    gen_cnt, gen_cnt_n;
    logic [WDOG_W-1:0]   wdog, wdog_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [REG_SIZE-1:0] nonce_buf, nonce_buf_n;

    logic                 busy_n, err_n, drbg_mode_n, drbg_init_n, drbg_next_n;
    logic                 out_valid_n, out_last_n;
    logic [WORD_SIZE-1:0] out_data_n;

    // Next-state, datapath and next-output decode
    always_comb begin
        state_n       = state;
        mode_n        = mode_reg;
        use_init_n    = use_init;
        inst_valid_n  = inst_valid;
        inst_mode_n   = inst_mode;
        reseed_pend_n = reseed_pend;
        gen_cnt_n     = gen_cnt;
        wdog_n        = wdog;
        idx_n         = idx;
        nonce_buf_n   = nonce_buf;

        case (state)
            S_IDLE: begin
                if (reseed_force) begin
                    reseed_pend_n = 1'b1;
                end
                if (req) begin
                    mode_n     = req_mode;
                    use_init_n = !inst_valid || reseed_pend || reseed_force ||
                                 (req_mode != inst_mode) || (gen_cnt == GEN_MAX);
                    wdog_n     = '0;
                    state_n    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_n = (wdog == WDOG_MAX) ? wdog : wdog + WDOG_W'(1);
                if (wdog == WDOG_TRIP) begin
                    state_n = S_ERR;
                end else if (!drbg_ready) begin
                    state_n = S_WAIT;
                    if (use_init) begin
                        gen_cnt_n     = GEN_W'(1);
                        inst_valid_n  = 1'b1;
                        reseed_pend_n = 1'b0;
                        inst_mode_n   = mode_reg;
                    end else begin
                        gen_cnt_n = gen_cnt + GEN_W'(1);
                    end
                end
            end
            S_WAIT: begin
                wdog_n = (wdog == WDOG_MAX) ? wdog : wdog + WDOG_W'(1);
                if (wdog == WDOG_TRIP) begin
                    state_n = S_ERR;
                end else if (drbg_ready && drbg_valid) begin
                    nonce_buf_n = drbg_nonce;
                    idx_n       = '0;
                    state_n     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (idx == IDX_LAST) begin
                        nonce_buf_n = '0;
                        idx_n       = '0;
                        state_n     = S_IDLE;
                    end else begin
                        nonce_buf_n = nonce_buf << WORD_SIZE;
                        idx_n       = idx + IDX_W'(1);
                    end
                end
            end
            S_ERR: begin
                nonce_buf_n  = '0;
                inst_valid_n = 1'b0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n      = (state_n != S_IDLE);
        err_n       = (state_n == S_ERR);
        drbg_init_n = (state_n == S_ISSUE) && use_init_n;
        drbg_next_n = (state_n == S_ISSUE) && !use_init_n;
        drbg_mode_n = (state_n == S_ISSUE) && mode_n;
        out_valid_n = (state_n == S_OUT);
        out_last_n  = (state_n == S_OUT) && (idx_n == IDX_LAST);
        out_data_n  = (state_n == S_OUT) ? nonce_buf_n[REG_SIZE-1 -: WORD_SIZE] : '0;
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            mode_reg    <= 1'b0;
            use_init    <= 1'b0;
            inst_valid  <= 1'b0;
            inst_mode   <= 1'b0;
            reseed_pend <= 1'b0;
            gen_cnt     <= '0;
            wdog        <= '0;
            idx         <= '0;
            nonce_buf   <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            drbg_mode   <= 1'b0;
            drbg_init   <= 1'b0;
            drbg_next   <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
        end else begin
            state       <= state_n;
            mode_reg    <= mode_n;
            use_init    <= use_init_n;
            inst_valid  <= inst_valid_n;
            inst_mode   <= inst_mode_n;
            reseed_pend <= reseed_pend_n;
            gen_cnt     <= gen_cnt_n;
            wdog        <= wdog_n;
            idx         <= idx_n;
            nonce_buf   <= nonce_buf_n;
            busy        <= busy_n;
            err         <= err_n;
            drbg_mode   <= drbg_mode_n;
            drbg_init   <= drbg_init_n;
            drbg_next   <= drbg_next_n;
            out_valid   <= out_valid_n;
            out_last    <= out_last_n;
            out_data    <= out_data_n;
        end
    end

endmodule

// File: doc/drbg_nonce_ctrl.md
# drbg_nonce_ctrl

Sequencer directly downstream of the HMAC-DRBG nonce generator. It decides whether each nonce request needs a fresh instantiation (`init`) or a continuation (`next`) of the DRBG, and handshakes the request to the generator. It captures the 384-bit nonce and streams it to the ECC datapath as 32-bit words over a valid/ready channel. A watchdog flags a hung generator.

## Interface
- `REG_SIZE`, 384: nonce width; must be a multiple of `WORD_SIZE`.
- `WORD_SIZE`, 32: output word width.
- `RESEED_INTERVAL`, 16: maximum number of nonces per instantiation.
- `TIMEOUT`, 4096: maximum number of cycles spent in ISSUE+WAIT before an error.
- `clk` in 1: clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `req` in 1: nonce request; sampled only in IDLE.
- `req_mode` in 1: 0 = keygen (seed), 1 = signing (privkey/hashed_msg); sampled with `req`.
- `reseed_force` in 1: the next request uses `init`; sticky until consumed.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: sticky watchdog error.
- `drbg_mode` out 1: mode driven to the generator.
- `drbg_init` out 1: init command to the generator.
- `drbg_next` out 1: next command to the generator.
- `drbg_ready` in 1: generator idle.
- `drbg_valid` in 1: generator nonce valid.
- `drbg_nonce` in REG_SIZE: generator nonce.
- `out_valid` out 1: output word valid.
- `out_ready` in 1: consumer ready.
- `out_data` out WORD_SIZE: nonce word, most-significant word first.
- `out_last` out 1: marks the final word.

## Operation
- Reset values: state=IDLE. All outputs are 0. `gen_cnt`=0, `inst_valid`=0, `reseed_pend`=0, watchdog=0, nonce buffer=0.
- State **IDLE**:
  - `reseed_force` sets `reseed_pend`.
  - On `req`, latch `req_mode` into `mode_reg`.
  - Compute `use_init` = !`inst_valid` | `reseed_pend` | (`mode_reg` changed vs last instantiation) | (`gen_cnt`==`RESEED_INTERVAL`).
  - Go to ISSUE.
  - `req` with `reseed_force` in the same cycle: the request uses `init`.
- State **ISSUE**:
  - Drive `drbg_mode`=`mode_reg`.
  - Drive exactly one of `drbg_init`/`drbg_next` (per `use_init`), held high until `drbg_ready` is sampled low.
  - Then go to WAIT, with the command dropped in the same cycle as the transition.
  - If `use_init`: `gen_cnt`<=1, `inst_valid`<=1, `reseed_pend`<=0, and record the instantiation mode. Otherwise `gen_cnt`+=1.
- State **WAIT**:
  - Commands are low.
  - When `drbg_ready`&`drbg_valid`, load `drbg_nonce` into the buffer, set word index=0, go to OUT.
- State **OUT**:
  - `out_valid`=1.
  - `out_data` = buffer[`REG_SIZE`-1 -: `WORD_SIZE`].
  - On `out_valid`&`out_ready`: shift the buffer left by `WORD_SIZE` (zero fill) and increment the index.
  - `out_last`=1 when index==`REG_SIZE`/`WORD_SIZE`-1.
  - After the last accepted word: clear the buffer to 0, go to IDLE.
  - `out_data` is 0 whenever `out_valid`=0.
- State **ERR**:
  - Entered from ISSUE/WAIT when the watchdog reaches `TIMEOUT`.
  - `err`=1, `busy`=1, commands low, buffer cleared.
  - Only `reset` exits ERR. `inst_valid` is cleared so that the first request after reset uses `init`.
- Watchdog:
  - Cleared on entry to ISSUE.
  - Increments each cycle in ISSUE/WAIT and saturates.
  - Not active in OUT; consumer backpressure is unbounded.
- `gen_cnt` width is clog2(`RESEED_INTERVAL`+1) and it never wraps: reaching `RESEED_INTERVAL` forces `init`.
- `reset` asserted in any state returns everything to reset values on the next edge. A generator mid-operation is reset by its own reset.

## Timing
- Command latency: `req` high in IDLE at edge N puts `drbg_init`/`drbg_next` high from cycle N+1.
- The command is held for a minimum of 1 cycle.
- First `out_valid` is asserted the cycle after `drbg_valid`&`drbg_ready` is sampled in WAIT.
- The output stream takes 12 words (default parameters), minimum 12 cycles with `out_ready` held high.
- `busy` deasserts the cycle after the last word handshake. A new `req` is accepted in that IDLE cycle, giving a minimum of 1 idle cycle between requests.
- `out_valid`/`out_data`/`out_last` are stable while `out_valid`&!`out_ready`.
- `drbg_valid` already high on arrival in WAIT, i.e. stale from the prior nonce: cannot capture, because the generator clears valid when it accepts the command, which happens before `drbg_ready` falls.

## Test plan
- Reset, `req`=1, `req_mode`=0, model returns nonce 0x0102…30 → `drbg_init` pulse, then words 0x01020304 … 0x2D2E2F30; `out_last` on word 12; buffer reads 0 afterwards.
- 17 consecutive mode-1 requests with `RESEED_INTERVAL`=16 → commands are init, next×15, init.
- Mode-1 request following a mode-0 request → `init`. `reseed_force` pulsed in IDLE → the next request uses `init` even when `gen_cnt`=3.
- Hold `out_ready`=0 for 20 cycles mid-stream, at word 5 → `out_data` stable, no word lost or duplicated, `err`=0.
- Model never asserts `drbg_valid`, `TIMEOUT`=64 → `err`=1 exactly 64 cycles after ISSUE entry; `req` ignored; `reset` clears `err`, and the next request issues `init`.
- `reset` asserted during OUT at word 7 → `out_valid`=0 next cycle, state IDLE, `inst_valid`=0.
